posit_extract_arbiter_es3: RTL
==============================

// Module: posit_extract_arbiter_es3
// PURPOSE
//  Shares one posit_extract_raw_es3 decode unit between N_REQ requesters (e.g. the operand
//  ports of adder/multiplier front-ends). Round-robin arbitration, 2-stage registered pipeline
//  around the combinational decoder. Valid/ready on every port; full throughput (1 decode/cycle).
//  Each result carries the requester's index as a tag so downstream logic can route it back.
// PARAMETERS
//  N_REQ   4   number of requesters (>=2)
//  TAG_W   $clog2(N_REQ)   width of requester tag
// PORTS
//  clk           in   1                               rising-edge clock
//  rst_n         in   1                               async active-low reset
//  in_valid      in   N_REQ                           per-requester valid
//  in_ready      out  N_REQ                           per-requester ready (one-hot or 0)
//  in_data       in   N_REQ*NBITS                     packed posits, requester i at [i*NBITS +: NBITS]
//  out_valid     out  1                               result valid
//  out_ready     in   1                               downstream ready
//  out_tag       out  TAG_W                           requester index of the result
//  out_result    out  POSIT_SERIALIZED_WIDTH_ES3      {sgn,scale,fraction,inf,zero} from decoder
//  out_absolute  out  NBITS-1                         |posit| without sign, from decoder
// BEHAVIOUR
//  Reset (async assert, sync deassert upstream): s1_valid=s2_valid=0, out_valid=0, in_ready=0,
//   rr_ptr=0, all data/tag regs 0. In-flight items are dropped; no partial output after reset.
//  Arbitration: grant = first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//   in_ready[i] = grant[i] & s1_ok. A transfer occurs when in_valid[i]&in_ready[i].
//   On transfer: rr_ptr <= (granted+1) mod N_REQ. No transfer -> rr_ptr holds.
//   in_ready may depend on in_valid (grant); requesters must hold in_valid/in_data stable until
//   accepted and must not depend on in_ready to raise in_valid.
//  Pipeline: S1 regs {posit, tag, s1_valid}; decoder combinational from S1; S2 regs
//   {result, absolute, tag, s2_valid}; outputs driven directly from S2.
//   s2_ok = ~s2_valid | out_ready; s1_ok = ~s1_valid | s2_ok.
//   S2 loads from S1 when s2_ok (s2_valid <= s1_valid); S1 loads on transfer when s1_ok,
//   else s1_valid <= s1_valid & ~s2_ok.
//  Latency: accept at edge T -> out_valid at edge T+2 (2 cycles) when not stalled.
//  Backpressure: out_ready=0 holds S2 data/tag stable; S1 still fills if empty; with both full,
//   in_ready=0 for all. Max 2 items in flight; no item lost or duplicated.
//  Simultaneous out handshake and S1->S2 move in same cycle: full throughput, no bubble.
//  Ordering: results leave in acceptance order (single in-order pipe).
//  Special values: decoder flags pass unchanged (0x0000_0000 -> zero=1; 0x8000_0000 -> inf=1).
//  Single requester active: granted every cycle it is valid, regardless of rr_ptr.
// STRUCTURE
//  Package posit_defines_es3: NBITS, ES, POSIT_SERIALIZED_WIDTH_ES3 (existing); add typedef
//   extract_req_t {logic [NBITS-1:0] posit;} and localparam EXTRACT_LATENCY = 2.
//  Sub-modules: posit_extract_raw_es3 (existing decoder, instantiated once between S1 and S2);
//   rr_arbiter #(N) (new, combinational grant + registered pointer, reusable elsewhere).
// TESTING
//  1 All 4 valid continuously, out_ready=1 -> out_tag sequence 0,1,2,3,0,1..; one result/cycle
//    after 2-cycle fill.
//  2 Req 2 alone sends 0x4000_0000 (1.0) -> 2 cycles later out_valid, tag=2, sgn=0, scale=0,
//    fraction=0, inf=0, zero=0.
//  3 Send 0x0000_0000 and 0x8000_0000 -> zero=1 then inf=1, in that order.
//  4 out_ready=0 for 6 cycles, all requesters valid -> exactly 2 accepted, in_ready=0 afterwards,
//    S2 outputs stable; release -> both delivered in order, then stream resumes.
//  5 rr_ptr=3, only req 1 and 3 valid -> grant 3 then 1 then 3 (fair alternation).
//  6 Assert rst_n=0 with 2 items in flight -> out_valid=0 immediately (async), no stale result
//    after release; first post-reset grant goes to lowest valid index >=0.

Source files
------------

// File: rtl/posit_defines_es3.sv
// Shared posit<32,3> constants and types for the decode front-end.
package posit_defines_es3;

  localparam int NBITS   = 32;
  localparam int ES      = 3;
  localparam int SCALE_W = 9;
  localparam int FRAC_W  = NBITS - 3 - ES;
  // {sgn, scale, fraction, inf, zero}
  localparam int POSIT_SERIALIZED_WIDTH_ES3 = 1 + SCALE_W + FRAC_W + 2;
  localparam int EXTRACT_LATENCY = 2;

  typedef struct packed {
    logic [NBITS-1:0] posit;
  } extract_req_t;

endpackage

// File: rtl/posit_extract_raw_es3.sv
// Combinational posit<32,3> field extraction: sign, scale (regime*8+exp),
// left-aligned fraction and special flags. Zero/NaR report scale=0, fraction=0.
module posit_extract_raw_es3
  import posit_defines_es3::*;
(
  input  logic [NBITS-1:0]                      posit_i,
  output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] result_o,
  output logic [NBITS-2:0]                      absolute_o
);

  logic               sgn, zero, inf, run_done;
  logic [NBITS-2:0]   body;
  logic [5:0]         run_len, shamt, regime_k;
  logic [ES-1:0]      expo;
  logic [FRAC_W-1:0]  frac;
  logic [SCALE_W-1:0] scale;

  always_comb begin
    sgn  = posit_i[NBITS-1];
    zero = (posit_i == '0);
    inf  = (posit_i == {1'b1, {(NBITS-1){1'b0}}});
    body = sgn ? -posit_i[NBITS-2:0] : posit_i[NBITS-2:0];

    run_len  = '0;
    run_done = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!run_done && (body[i] == body[NBITS-2])) run_len = run_len + 6'd1;
      else run_done = 1'b1;
    end

    // skip regime run plus its terminating bit; a run of 31 shifts everything out
    shamt = run_len + 6'd1;
    {expo, frac} = (ES + FRAC_W)'((body << shamt) >> 2);
    regime_k = body[NBITS-2] ? (run_len - 6'd1) : (6'd0 - run_len);
    scale    = {regime_k, expo};

    if (zero || inf) result_o = {sgn, {SCALE_W{1'b0}}, {FRAC_W{1'b0}}, inf, zero};
    else             result_o = {sgn, scale, frac, 1'b0, 1'b0};
    absolute_o = body;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational first-hit search from a registered
// pointer, which moves past the winner only when the grant is consumed.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] grant_idx_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o = PTR_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (advance_i) ptr_d = (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/posit_extract_arbiter_es3.sv
// Shares one posit decoder between N_REQ requesters: round-robin grant,
// S1 operand register, decoder, S2 result register; results tagged by requester.
module posit_extract_arbiter_es3
  import posit_defines_es3::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_W = $clog2(N_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_REQ-1:0]                      in_valid,
  output logic [N_REQ-1:0]                      in_ready,
  input  logic [N_REQ*NBITS-1:0]                in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [TAG_W-1:0]                      out_tag,
  output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] out_result,
  output logic [NBITS-2:0]                      out_absolute
);

  localparam int RW = POSIT_SERIALIZED_WIDTH_ES3;

  logic [N_REQ-1:0] grant;
  logic [TAG_W-1:0] grant_idx;
  logic             run_q, s1_ok, s2_ok, xfer;
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  extract_req_t     s1_req_q, s1_req_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [RW-1:0]    dec_result, s2_result_q, s2_result_d;
  logic [NBITS-2:0] dec_absolute, s2_abs_q, s2_abs_d;

  rr_arbiter #(.N(N_REQ), .PTR_W(TAG_W)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (in_valid),
    .advance_i  (xfer),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  posit_extract_raw_es3 u_dec (
    .posit_i   (s1_req_q.posit),
    .result_o  (dec_result),
    .absolute_o(dec_absolute)
  );

  always_comb begin
    s2_ok    = ~s2_valid_q | out_ready;
    s1_ok    = ~s1_valid_q | s2_ok;
    // run_q keeps in_ready low while reset is held and for the first edge after it
    in_ready = (s1_ok && run_q) ? grant : '0;
    xfer     = |(in_valid & in_ready);

    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    s1_tag_d   = s1_tag_q;
    if (s1_ok) begin
      s1_valid_d = xfer;
      if (xfer) begin
        s1_req_d.posit = in_data[int'(grant_idx)*NBITS +: NBITS];
        s1_tag_d       = grant_idx;
      end
    end

    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_abs_d    = s2_abs_q;
    s2_tag_d    = s2_tag_q;
    if (s2_ok) begin
      s2_valid_d  = s1_valid_q;
      s2_result_d = dec_result;
      s2_abs_d    = dec_absolute;
      s2_tag_d    = s1_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_abs_q    <= '0;
      s2_tag_q    <= '0;
    end else begin
      run_q       <= 1'b1;
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_abs_q    <= s2_abs_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_tag      = s2_tag_q;
  assign out_result   = s2_result_q;
  assign out_absolute = s2_abs_q;

endmodule
